// File: rtl/adder_2_pkg.sv
// Shared constants and types for the registered two-operand adder cell.
// Used by adder_2_sat (arithmetic) and adder_2_reg (handshake + output register).
package adder_2_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 32;

    typedef struct packed {
        logic carry;
        logic ovf;
    } add_status_t;

endpackage

// File: rtl/adder_2_sat.sv
// Combinational add of a and b with raw carry and mode-dependent overflow.
// Saturation on overflow is built only when ADDER_2_REG_SAT_EN is defined; otherwise the sum wraps.
module adder_2_sat
    import adder_2_pkg::*;
#(
    parameter int WIDTH       = ADDER_WIDTH_DEFAULT,
    parameter int SIGNED_MODE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output add_status_t      status
);

    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] wrap;
    logic             ovf_raw;

    assign full = {1'b0, a} + {1'b0, b};
    assign wrap = full[WIDTH-1:0];

    generate
        if (SIGNED_MODE != 0) begin : g_signed_ovf
            assign ovf_raw = (a[WIDTH-1] == b[WIDTH-1]) && (wrap[WIDTH-1] != a[WIDTH-1]);
        end else begin : g_unsigned_ovf
            assign ovf_raw = full[WIDTH];
        end
    endgenerate

    assign status = '{carry: full[WIDTH], ovf: ovf_raw};

`ifdef ADDER_2_REG_SAT_EN
    // Signed overflow only happens when a and b share a sign, so a's sign picks the clamp direction.
    logic [WIDTH-1:0] sat_value;

    generate
        if (SIGNED_MODE != 0) begin : g_signed_sat
            assign sat_value = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin : g_unsigned_sat
            assign sat_value = {WIDTH{1'b1}};
        end
    endgenerate

    assign sum = ovf_raw ? sat_value : wrap;
`else
    assign sum = wrap;
`endif

endmodule

// File: rtl/adder_2_reg.sv
// Registered two-operand adder with valid/ready on both sides; one result register, latency 1.
// Optional output saturation is selected with the ADDER_2_REG_SAT_EN macro (see adder_2_sat).
module adder_2_reg
    import adder_2_pkg::*;
#(
    parameter int WIDTH       = ADDER_WIDTH_DEFAULT,
    parameter int SIGNED_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] sum_next;
    add_status_t      status_next;

    logic [WIDTH-1:0] out_reg;
    add_status_t      status_reg;
    logic             out_valid_reg;
    logic             accept;

    adder_2_sat #(
        .WIDTH       (WIDTH),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_sat (
        .a      (a),
        .b      (b),
        .sum    (sum_next),
        .status (status_next)
    );

    // Ready whenever the register is empty or being drained this cycle, so a full stream never bubbles.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            status_reg    <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_reg       <= sum_next;
            status_reg    <= status_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign carry     = status_reg.carry;
    assign ovf       = status_reg.ovf;

endmodule

// File: tb/tb_adder_2_reg.sv
// Bench for adder_2_reg: unsigned and signed instances share stimulus, each with its own scoreboard,
// plus a 15-instance, 4-level adder tree summing 1..16.
module tb_adder_2_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         in_ready_u, out_valid_u, carry_u, ovf_u;
    logic [W-1:0] out_u;
    logic         in_ready_s, out_valid_s, carry_s, ovf_s;
    logic [W-1:0] out_s;

    logic [33:0]  q_u[$];
    logic [33:0]  q_s[$];
    int           n_compared   = 0;
    int           n_mismatched = 0;
    int           n_results    = 0;
    int           n_accepted   = 0;

    always #5 clk = ~clk;

    adder_2_reg #(.WIDTH(W), .SIGNED_MODE(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .a(a), .b(b),
        .out_valid(out_valid_u), .out_ready(out_ready), .out(out_u), .carry(carry_u), .ovf(ovf_u)
    );

    adder_2_reg #(.WIDTH(W), .SIGNED_MODE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
        .out_valid(out_valid_s), .out_ready(out_ready), .out(out_s), .carry(carry_s), .ovf(ovf_s)
    );

    // Adder tree in heap order: node n has children 2n and 2n+1; nodes 8..15 are leaves.
    logic         tree_go;
    logic [W-1:0] t_a[1:15];
    logic [W-1:0] t_b[1:15];
    logic [W-1:0] t_out[1:15];
    logic         t_in_valid[1:15];
    logic         t_in_ready[1:15];
    logic         t_valid[1:15];
    logic         t_out_ready[1:15];
    logic         t_carry[1:15];
    logic         t_ovf[1:15];

    genvar gi;
    generate
        for (gi = 1; gi <= 15; gi++) begin : g_tree
            if (gi >= 8) begin : g_leaf
                assign t_a[gi]        = W'(2 * (gi - 8) + 1);
                assign t_b[gi]        = W'(2 * (gi - 8) + 2);
                assign t_in_valid[gi] = tree_go;
            end else begin : g_node
                assign t_a[gi]        = t_out[2*gi];
                assign t_b[gi]        = t_out[2*gi+1];
                assign t_in_valid[gi] = t_valid[2*gi] && t_valid[2*gi+1];
            end
            if (gi == 1) begin : g_root
                assign t_out_ready[gi] = 1'b1;
            end else begin : g_child
                assign t_out_ready[gi] = t_in_ready[gi/2] && t_valid[gi^1];
            end
            adder_2_reg #(.WIDTH(W), .SIGNED_MODE(0)) u_node (
                .clk(clk), .rst(rst), .in_valid(t_in_valid[gi]), .in_ready(t_in_ready[gi]),
                .a(t_a[gi]), .b(t_b[gi]), .out_valid(t_valid[gi]), .out_ready(t_out_ready[gi]),
                .out(t_out[gi]), .carry(t_carry[gi]), .ovf(t_ovf[gi])
            );
        end
    endgenerate

    // Reference result packed as {carry, ovf, out}.
    function automatic logic [33:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        logic [W:0]   f;
        logic [W-1:0] s;
        logic         c;
        logic         o;
        f = {1'b0, x} + {1'b0, y};
        c = f[W];
        s = f[W-1:0];
        if (sgn) o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        else     o = c;
`ifdef ADDER_2_REG_SAT_EN
        if (o) begin
            if (sgn) s = x[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else     s = 32'hFFFF_FFFF;
        end
`endif
        return {c, o, s};
    endfunction

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic v, input logic r);
        @(posedge clk);
        #1;
        a         = ta;
        b         = tb_;
        in_valid  = v;
        out_ready = r;
        #1;
        if (v && in_ready_u && !rst) begin
            n_accepted++;
            q_u.push_back(model(ta, tb_, 1'b0));
            q_s.push_back(model(ta, tb_, 1'b1));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_u) begin
                if (q_u.size() == 0) begin
                    check_value("u_spurious", 64'd1, 64'd0);
                end else begin
                    check_value(out_ready ? "u_result" : "u_hold", {30'd0, carry_u, ovf_u, out_u}, {30'd0, q_u[0]});
                    if (out_ready) begin
                        $display("xfer u: out=%h carry=%b ovf=%b", out_u, carry_u, ovf_u);
                        n_results++;
                        void'(q_u.pop_front());
                    end
                end
                if (!out_ready) check_value("u_stall_ready", {63'd0, in_ready_u}, 64'd0);
            end else begin
                check_value("u_idle_ready", {63'd0, in_ready_u}, 64'd1);
            end
            if (out_valid_s) begin
                if (q_s.size() == 0) begin
                    check_value("s_spurious", 64'd1, 64'd0);
                end else begin
                    check_value(out_ready ? "s_result" : "s_hold", {30'd0, carry_s, ovf_s, out_s}, {30'd0, q_s[0]});
                    if (out_ready) void'(q_s.pop_front());
                end
                if (!out_ready) check_value("s_stall_ready", {63'd0, in_ready_s}, 64'd0);
            end
        end
    end

    initial begin
        int           acc_before;
        int           res_before;
        bit           found;
        logic [W-1:0] root_sum;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tree_go   = 1'b0;
        found     = 1'b0;
        root_sum  = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_value("rst_valid", {62'd0, out_valid_u, out_valid_s}, 64'd0);
        check_value("rst_out", {out_u, out_s}, 64'd0);
        check_value("rst_flags", {60'd0, carry_u, ovf_u, carry_s, ovf_s}, 64'd0);
        check_value("rst_ready", {62'd0, in_ready_u, in_ready_s}, 64'd3);

        // Directed arithmetic corners, then a few random pairs.
        step(32'd1, 32'd2, 1'b1, 1'b1);
        step(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
        step(32'h7FFF_FFFF, 32'd1, 1'b1, 1'b1);
        step(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        step(32'd0, 32'd0, 1'b1, 1'b1);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        step(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step($urandom, $urandom, 1'b1, 1'b1);
        step(32'd0, 32'd0, 1'b0, 1'b1);
        step(32'd0, 32'd0, 1'b0, 1'b1);

        // Backpressure: hold for three cycles with new inputs offered, then drain + accept together.
        acc_before = n_accepted;
        step(32'd5, 32'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(32'd9, 32'd9, 1'b1, 1'b0);
        step(32'd7, 32'd8, 1'b1, 1'b1);
        step(32'd0, 32'd0, 1'b0, 1'b1);
        step(32'd0, 32'd0, 1'b0, 1'b1);
        check_value("bp_accepts", 64'(n_accepted - acc_before), 64'd2);

        // Full-throughput stream of 16 pairs.
        acc_before = n_accepted;
        res_before = n_results;
        for (int i = 0; i < 16; i++) step($urandom, $urandom, 1'b1, 1'b1);
        check_value("stream_accepts", 64'(n_accepted - acc_before), 64'd16);
        step(32'd0, 32'd0, 1'b0, 1'b1);
        step(32'd0, 32'd0, 1'b0, 1'b1);
        check_value("stream_results", 64'(n_results - res_before), 64'd16);

        // Reset while a result is pending and a new transfer is offered.
        step(32'd3, 32'd4, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 32'hFFFF_FFFF;
        b         = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check_value("rstmid_valid", {62'd0, out_valid_u, out_valid_s}, 64'd0);
        check_value("rstmid_out", {out_u, out_s}, 64'd0);
        check_value("rstmid_flags", {60'd0, carry_u, ovf_u, carry_s, ovf_s}, 64'd0);
        q_u.delete();
        q_s.delete();
        rst      = 1'b0;
        in_valid = 1'b0;

        // Tree of 15 instances over 1..16.
        @(posedge clk);
        #1;
        tree_go = 1'b1;
        @(posedge clk);
        #1;
        tree_go = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (t_valid[1]) begin
                found    = 1'b1;
                root_sum = t_out[1];
            end
        end
        $display("xfer tree: root=%h", root_sum);
        check_value("tree_done", {63'd0, found}, 64'd1);
        check_value("tree_sum", {32'd0, root_sum}, 64'h88);

        check_value("u_queue_empty", 64'(q_u.size()), 64'd0);
        check_value("s_queue_empty", 64'(q_s.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
